// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run-control sequencer: delay, staggered precharge, budgeted run, finish pulse
// Outputs decode from the state/counter flops only, so inputs never reach outputs combinationally.
module run_ctrl #(
  parameter int PRE_DELAY  = 2,
  parameter int PRE_LEN    = 2,
  parameter int N_CH       = 2,
  parameter int STAGGER    = 1,
  parameter int MAX_CYCLES = 10,
  parameter int FINISH_LEN = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             abort,
  output logic [N_CH-1:0]  precharge,
  output logic             running,
  output logic             finish,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    PRECH  = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(PRE_DELAY - 1);
  localparam logic [CNT_W-1:0] PCH_LAST = CNT_W'((N_CH - 1) * STAGGER + PRE_LEN - 1);
  localparam logic [CNT_W-1:0] FIN_LAST = CNT_W'(FINISH_LEN - 1);
  localparam logic [CNT_W-1:0] MAXC     = CNT_W'(MAX_CYCLES);

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cc, cc_nxt, cc_inc;
  logic             to, to_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
      cc  <= '0;
      to  <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      cc  <= cc_nxt;
      to  <= to_nxt;
    end
  end

  // cnt is the cycle index within DELAY, PRECH and FINISH; it restarts at 0 on every state change.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt + 1'b1;
    cc_nxt  = cc;
    to_nxt  = to;
    cc_inc  = cc + 1'b1;
    case (st)
      IDLE, DONE: begin
        cnt_nxt = '0;
        if (start) begin
          st_nxt = (PRE_DELAY == 0) ? PRECH : DELAY;
          cc_nxt = '0;
          to_nxt = 1'b0;
        end
      end
      DELAY: begin
        if (abort) begin
          st_nxt  = FINISH;
          cnt_nxt = '0;
          to_nxt  = 1'b0;
        end else if (cnt == DLY_LAST) begin
          st_nxt  = PRECH;
          cnt_nxt = '0;
        end
      end
      PRECH: begin
        if (abort) begin
          st_nxt  = FINISH;
          cnt_nxt = '0;
          to_nxt  = 1'b0;
        end else if (cnt == PCH_LAST) begin
          st_nxt  = RUN;
          cnt_nxt = '0;
        end
      end
      RUN: begin
        // Every RUN edge counts, including the exit edge; abort and halt beat budget exhaustion.
        cnt_nxt = '0;
        cc_nxt  = cc_inc;
        if (abort || halt) begin
          st_nxt = FINISH;
          to_nxt = 1'b0;
        end else if (cc_inc == MAXC) begin
          st_nxt = FINISH;
          to_nxt = 1'b1;
        end
      end
      FINISH: begin
        if (cnt == FIN_LAST) begin
          st_nxt  = DONE;
          cnt_nxt = '0;
        end
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_pch
    localparam logic [CNT_W-1:0] LO = CNT_W'(k * STAGGER);
    localparam logic [CNT_W-1:0] HI = CNT_W'(k * STAGGER + PRE_LEN);
    if (k == 0) begin : g_first
      assign precharge[k] = (st == PRECH) && (cnt < HI);
    end else begin : g_rest
      assign precharge[k] = (st == PRECH) && (cnt >= LO) && (cnt < HI);
    end
  end

  assign running     = (st == RUN);
  assign finish      = (st == FINISH);
  assign done        = (st == DONE);
  assign timeout     = to;
  assign cycle_count = cc;
  assign state       = st;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run-control sequencer for the SPARC datapath.
- After start, it waits a programmable delay, then issues staggered precharge pulses on N_CH channels (register file, RAM banks, ...).
- It then runs the datapath until halt, abort or a cycle-budget timeout, and finally issues a finish pulse of programmable length.
- It replaces fixed-delay bench sequencing with a parametrised, restartable FSM that reports status.

Parameters:
- PRE_DELAY, 2, cycles spent in DELAY before precharge; 0 skips DELAY.
- PRE_LEN, 2, high-time of each precharge channel in cycles; must be >=1.
- N_CH, 2, number of precharge channels; must be >=1.
- STAGGER, 1, cycle offset between consecutive channel pulses; 0 means all channels pulse together.
- MAX_CYCLES, 10, RUN-cycle budget before timeout; must be >=1.
- FINISH_LEN, 2, finish high-time in cycles; must be >=1.
- CNT_W, 16, width of the cycle counter and internal counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a sequence; honoured only in IDLE or DONE.
- halt  in  1  datapath halted; honoured only in RUN.
- abort  in  1  force early finish; honoured in DELAY, PRECH, RUN.
- precharge  out  N_CH  per-channel precharge strobes.
- running  out  1  high while in RUN.
- finish  out  1  finish strobe.
- done  out  1  sequence complete; sticky until the next start.
- timeout  out  1  last run ended on budget exhaustion.
- cycle_count  out  CNT_W  number of RUN cycles in the current or last run.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- General:
  - Moore FSM. All outputs decode from registered state/counter flops only; there is no combinational input-to-output path.
  - Inputs are sampled on the rising edge of clk.
- Reset (rst_n=0 at an edge), taking priority over everything, including mid-operation:
  - state=IDLE, all counters 0.
  - precharge=0, running=0, finish=0, done=0, timeout=0, cycle_count=0.
- State encodings: IDLE=0, DELAY=1, PRECH=2, RUN=3, FINISH=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE:
  - start=1 -> DELAY, or PRECH if PRE_DELAY=0.
  - On this edge, cycle_count and timeout clear.
- DELAY:
  - Occupies exactly PRE_DELAY cycles, then PRECH.
- PRECH:
  - Lasts (N_CH-1)*STAGGER+PRE_LEN cycles, then RUN.
  - With p the PRECH cycle index starting at 0, precharge[k] is high iff k*STAGGER <= p < k*STAGGER+PRE_LEN.
  - Overlap between channels is legal.
- RUN:
  - running=1.
  - cycle_count increments on every edge sampled in RUN, including the exit edge, so it equals the number of RUN cycles.
  - Exit on halt=1 -> FINISH, with timeout=0.
  - Exit when the increment would make cycle_count equal MAX_CYCLES -> FINISH, with timeout=1.
  - If halt and budget exhaustion occur on the same edge, halt wins and timeout=0.
  - cycle_count never exceeds MAX_CYCLES.
- abort:
  - In DELAY/PRECH/RUN: -> FINISH on the next edge, with timeout=0.
  - All precharge outputs drop immediately with the state change.
  - cycle_count holds its value; it still counts the abort edge if the abort occurs in RUN.
  - Ignored in IDLE, FINISH, DONE.
  - abort wins over halt and timeout on the same edge.
- FINISH:
  - finish=1 for exactly FINISH_LEN cycles, then DONE.
  - Not interruptible except by reset.
- DONE:
  - done=1; cycle_count and timeout hold.
  - start=1 -> restarts exactly as from IDLE (done drops, counters clear on the same edge).
- start outside IDLE/DONE is ignored. halt outside RUN is ignored.

Test Plan:
All scenarios use the default parameters. E0 is the first edge at which start=1 is sampled.
1. Reset, then start pulse at E0, halt held 0:
   - DELAY after E0 and E1.
   - precharge=01 after E2, 11 after E3, 10 after E4, 00 after E5.
   - RUN after E5.
   - timeout=1 and cycle_count=10 after E15.
   - finish=1 after E15 and E16.
   - done=1 after E17.
2. As in 1, with halt=1 sampled on the 4th RUN edge -> cycle_count=4, timeout=0, finish high for 2 cycles, then done=1.
3. halt=1 on the same edge as budget exhaustion (the 10th RUN edge) -> timeout=0, cycle_count=10.
4. abort=1 on the edge after E3 (in PRECH) -> state=FINISH next cycle, precharge=00, cycle_count=0, finish high for 2 cycles, then DONE.
5. rst_n=0 for one edge in mid RUN -> all outputs 0 and state=0 on that edge; a subsequent start repeats scenario 1 timing exactly.
6. From DONE after scenario 2, start=1 -> done=0, cycle_count=0, timeout=0 on the same edge; halt and abort pulses given while in IDLE are ignored.
